// File: rtl/gpio_input_conditioner.sv
// Per-pin GPIO input conditioning: synchroniser, optional debounce filter and
// qualified edge detection. Outputs a filtered level and one-cycle change pulses.
module gpio_input_conditioner #(
  parameter int unsigned WB_DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [WB_DATA_WIDTH-1:0]      i_gpio_raw,
  input  logic [DEBOUNCE_CNT_WIDTH-1:0] i_debounce_period,
  input  logic [WB_DATA_WIDTH-1:0]      i_debounce_en,
  input  logic [WB_DATA_WIDTH-1:0]      i_rise_en,
  input  logic [WB_DATA_WIDTH-1:0]      i_fall_en,
  output logic [WB_DATA_WIDTH-1:0]      o_gpio_level,
  output logic [WB_DATA_WIDTH-1:0]      o_pin_change,
  output logic                          o_armed
);

  localparam logic [2:0]                    SETTLE_LAST = 3'(SYNC_STAGES);
  localparam logic [DEBOUNCE_CNT_WIDTH-1:0] CNT_ONE     = DEBOUNCE_CNT_WIDTH'(1);

  logic [WB_DATA_WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WB_DATA_WIDTH-1:0]      s;
  logic [2:0]                    settle_cnt;
  logic [DEBOUNCE_CNT_WIDTH-1:0] cnt_q    [WB_DATA_WIDTH];
  logic [DEBOUNCE_CNT_WIDTH-1:0] cnt_next [WB_DATA_WIDTH];
  logic [WB_DATA_WIDTH-1:0]      level_next;
  logic [WB_DATA_WIDTH-1:0]      change_next;
  logic [DEBOUNCE_CNT_WIDTH-1:0] period_m1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_gpio_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Armed on the (SYNC_STAGES+1)th edge after release, once the chain holds real pad data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      settle_cnt <= '0;
      o_armed    <= 1'b0;
    end else if (!o_armed) begin
      if (settle_cnt == SETTLE_LAST) o_armed <= 1'b1;
      else                           settle_cnt <= settle_cnt + 3'd1;
    end
  end

  assign period_m1 = i_debounce_period - CNT_ONE;

  always_comb begin
    level_next  = o_gpio_level;
    change_next = '0;
    for (int unsigned i = 0; i < WB_DATA_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!o_armed) begin
        level_next[i] = s[i];
      end else if (s[i] != o_gpio_level[i]) begin
        if (!i_debounce_en[i] || i_debounce_period == '0) begin
          level_next[i] = s[i];
        end else if (cnt_q[i] >= period_m1) begin
          level_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // Pulse is registered alongside the level so both appear in the same cycle.
      change_next[i] = o_armed &
                       (( level_next[i] & ~o_gpio_level[i] & i_rise_en[i]) |
                        (~level_next[i] &  o_gpio_level[i] & i_fall_en[i]));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_gpio_level <= '0;
      o_pin_change <= '0;
      for (int unsigned i = 0; i < WB_DATA_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      o_gpio_level <= level_next;
      o_pin_change <= change_next;
      for (int unsigned i = 0; i < WB_DATA_WIDTH; i++) cnt_q[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner (SYNC_STAGES=2).
module tb_gpio_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raw;
  logic [15:0] period;
  logic [31:0] deb_en, rise_en, fall_en;
  logic [31:0] level, change;
  logic        armed;
  int          total = 0;
  int          bad   = 0;

  gpio_input_conditioner #(
    .WB_DATA_WIDTH(32),
    .DEBOUNCE_CNT_WIDTH(16),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_gpio_raw(raw),
    .i_debounce_period(period),
    .i_debounce_en(deb_en),
    .i_rise_en(rise_en),
    .i_fall_en(fall_en),
    .o_gpio_level(level),
    .o_pin_change(change),
    .o_armed(armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    raw     = 32'hFFFF_0000;
    period  = 16'd4;
    deb_en  = 32'h0000_0008;
    rise_en = 32'hFFFF_FFDF;
    fall_en = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_level", level, 32'h0);
    check("rst_armed", {31'd0, armed}, 32'd0);
    check("rst_change", change, 32'h0);

    // 1: arming after release
    @(negedge clk) rst = 1'b0;
    tick(); check("arm1", {31'd0, armed}, 32'd0); check("arm1_chg", change, 32'h0);
    tick(); check("arm2", {31'd0, armed}, 32'd0); check("arm2_chg", change, 32'h0);
    tick(); check("arm3", {31'd0, armed}, 32'd1);
    check("arm3_level", level, 32'hFFFF_0000);
    check("arm3_chg", change, 32'h0);
    tick(); check("arm4_chg", change, 32'h0);

    // 2: bypass rise on pin0
    raw[0] = 1'b1;
    tick(); tick();
    check("byp_lvl_k", level, 32'hFFFF_0000);
    check("byp_chg_k", change, 32'h0);
    tick();
    check("byp_lvl", level, 32'hFFFF_0001);
    check("byp_chg", change, 32'h0000_0001);
    tick();
    check("byp_chg_off", change, 32'h0);

    // 3: debounce P=4 on pin3, 3-cycle glitch rejected then 4-cycle accepted
    raw[3] = 1'b1;
    tick(); tick(); tick();
    raw[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("glitch_lvl", level, 32'hFFFF_0001);
      check("glitch_chg", change, 32'h0);
    end
    raw[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("deb_lvl_k3", level, 32'hFFFF_0001);
    check("deb_chg_k3", change, 32'h0);
    tick();
    check("deb_lvl", level, 32'hFFFF_0009);
    check("deb_chg", change, 32'h0000_0008);
    tick();
    check("deb_chg_off", change, 32'h0);

    // 4: pin5 fall-only reporting
    raw[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p5_rise_chg", change, 32'h0);
    end
    check("p5_lvl_hi", level, 32'hFFFF_0029);
    raw[5] = 1'b0;
    tick(); tick();
    check("p5_fall_k", change, 32'h0);
    tick();
    check("p5_lvl_lo", level, 32'hFFFF_0009);
    check("p5_fall_chg", change, 32'h0000_0020);
    tick();
    check("p5_fall_off", change, 32'h0);

    // 5: period lowered mid-count on pin3 (falling)
    period = 16'd10;
    raw[3] = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("p_rw_hold", level, 32'hFFFF_0009);
    period = 16'd4;
    tick();
    check("p_rw_lvl", level, 32'hFFFF_0001);
    check("p_rw_chg", change, 32'h0000_0008);

    // simultaneous bypass edges on pins 1 and 2
    raw[2:1] = 2'b11;
    tick(); tick(); tick();
    check("multi_lvl", level, 32'hFFFF_0007);
    check("multi_chg", change, 32'h0000_0006);

    // 6: async reset mid-count, then re-arm without pulses
    period = 16'd10;
    raw[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("ar_level", level, 32'h0);
    check("ar_armed", {31'd0, armed}, 32'd0);
    check("ar_chg", change, 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rearm_chg", change, 32'h0);
      if (i == 1) check("rearm_armed_lo", {31'd0, armed}, 32'd0);
      if (i == 2) check("rearm_armed", {31'd0, armed}, 32'd1);
    end
    check("rearm_lvl", level, 32'hFFFF_000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
